// File: rtl/bfs_frontier_queue_pkg.sv
// bfs_frontier_queue_pkg: shared grid defaults and state types for the BFS engine
package bfs_frontier_queue_pkg;
  localparam int DEF_GRID_W = 32;
  localparam int DEF_GRID_H = 32;
  typedef enum logic [2:0] {
    IDLE,
    CHECK_NEIGHBORS,
    VISIT_NODES1,
    VISIT_NODES2,
    VISIT_NODES3,
    VISIT_NODES4,
    DONE
  } state_t;
  typedef enum logic {Q_CLEAR, Q_READY} q_state_t;
endpackage

// File: rtl/bfs_frontier_queue_if.sv
// bfs_frontier_queue_if: push/pop handshake and status between BFS controller and frontier queue
interface bfs_frontier_queue_if #(
  parameter int XW = 6,
  parameter int YW = 6,
  parameter int CW = 11
);
  logic          clear;
  logic          push_valid;
  logic [XW-1:0] push_x;
  logic [YW-1:0] push_y;
  logic          push_ready;
  logic          pop_valid;
  logic          pop_ready;
  logic [XW-2:0] pop_x;
  logic [YW-2:0] pop_y;
  logic          busy;
  logic          dup_drop;
  logic          oob_drop;
  logic [CW-1:0] count;
  modport master (
    output clear, push_valid, push_x, push_y, pop_ready,
    input  push_ready, pop_valid, pop_x, pop_y, busy, dup_drop, oob_drop, count
  );
  modport slave (
    input  clear, push_valid, push_x, push_y, pop_ready,
    output push_ready, pop_valid, pop_x, pop_y, busy, dup_drop, oob_drop, count
  );
endinterface

// File: rtl/bfs_visited_map.sv
// bfs_visited_map: row-word visited bitmap with combinational test, bit set and whole-row clear
module bfs_visited_map #(
  parameter int GRID_W = 32,
  parameter int GRID_H = 32,
  localparam int XA = $clog2(GRID_W),
  localparam int YA = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          clr_en,
  input  logic [YA-1:0] clr_row,
  input  logic          set_en,
  input  logic [XA-1:0] x,
  input  logic [YA-1:0] y,
  output logic          hit
);
  logic [GRID_W-1:0] rows_q [GRID_H];
  assign hit = rows_q[y][x];
  // sweep clears one row per cycle; otherwise mark newly enqueued cells
  always_ff @(posedge clk) begin
    if (clr_en) rows_q[clr_row] <= '0;
    else if (set_en) rows_q[y][x] <= 1'b1;
  end
endmodule

// File: rtl/bfs_frontier_queue.sv
// bfs_frontier_queue: BFS frontier FIFO that drops out-of-grid and already-visited pushes
module bfs_frontier_queue
  import bfs_frontier_queue_pkg::*;
#(
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H,
  parameter int DEPTH  = GRID_W * GRID_H
) (
  input logic Clk,
  input logic Reset_n,
  bfs_frontier_queue_if.slave q
);
  localparam int XA = $clog2(GRID_W);
  localparam int YA = $clog2(GRID_H);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  q_state_t state_q, state_d;
  logic [YA-1:0] row_q, row_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic dup_q, dup_d, oob_q, oob_d;
  logic [XA+YA-1:0] mem_q [DEPTH];
  logic push_fire, pop_fire, oob, hit, acc;
  bfs_visited_map #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_map (
    .clk    (Clk),
    .clr_en (state_q == Q_CLEAR),
    .clr_row(row_q),
    .set_en (acc),
    .x      (q.push_x[XA-1:0]),
    .y      (q.push_y[YA-1:0]),
    .hit    (hit)
  );
  // state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= Q_CLEAR;
    else state_q <= state_d;
  end
  // clear restarts the sweep; the last swept row hands over to normal operation
  always_comb state_d = q.clear ? Q_CLEAR : (state_q == Q_CLEAR && row_q == YA'(GRID_H - 1)) ? Q_READY : state_q;
  // state-derived handshake and status outputs; count MSB alone marks full
  always_comb begin
    q.busy = state_q == Q_CLEAR;
    q.push_ready = state_q == Q_READY && !count_q[CW-1];
    q.pop_valid = state_q == Q_READY && count_q != '0;
  end
  assign {q.pop_x, q.pop_y} = q.pop_valid ? mem_q[head_q] : '0;
  assign q.count = count_q;
  assign q.dup_drop = dup_q;
  assign q.oob_drop = oob_q;
  // classify pushes and advance pointers; clear overrides both handshakes
  always_comb begin
    oob = q.push_x[XA] | q.push_y[YA];
    push_fire = q.push_valid && q.push_ready && !q.clear;
    pop_fire = q.pop_valid && q.pop_ready && !q.clear;
    acc = push_fire && !oob && !hit;
    oob_d = push_fire && oob;
    dup_d = push_fire && !oob && hit;
    row_d = q.clear ? '0 : row_q + YA'(state_q == Q_CLEAR);
    head_d = q.clear ? '0 : head_q + AW'(pop_fire);
    tail_d = q.clear ? '0 : tail_q + AW'(acc);
    count_d = q.clear ? '0 : count_q + CW'(acc) - CW'(pop_fire);
  end
  // datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      row_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      dup_q <= 1'b0;
      oob_q <= 1'b0;
    end else begin
      row_q <= row_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      dup_q <= dup_d;
      oob_q <= oob_d;
    end
  end
  // FIFO storage write at tail
  always_ff @(posedge Clk) begin
    if (acc) mem_q[tail_q] <= {q.push_x[XA-1:0], q.push_y[YA-1:0]};
  end
endmodule

// File: tb/tb_bfs_frontier_queue.sv
// tb_bfs_frontier_queue: vector table, corner sequences and random model check of the frontier queue
module tb_bfs_frontier_queue;
  localparam int W = 32;
  localparam int H = 32;
  localparam int D = W * H;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;
  bfs_frontier_queue_if #(.XW(6), .YW(6), .CW(11)) q ();
  bfs_frontier_queue_if #(.XW(6), .YW(6), .CW(4)) s ();
  bfs_frontier_queue #(.GRID_W(W), .GRID_H(H), .DEPTH(D)) dut (.Clk(Clk), .Reset_n(Reset_n), .q(q));
  bfs_frontier_queue #(.GRID_W(W), .GRID_H(H), .DEPTH(8)) dut_s (.Clk(Clk), .Reset_n(Reset_n), .q(s));
  typedef struct {
    string n;
    bit pv;
    int x, y;
    bit pr;
    int cnt;
    bit dup, oob, pvl;
    int px, py;
  } vec_t;
  vec_t tv[$];
  int checks = 0;
  int errors = 0;
  int mq[$];
  bit vis[W][H];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic drv(input bit pv, input int x, input int y, input bit pr);
    q.push_valid = pv;
    q.push_x = 6'(x);
    q.push_y = 6'(y);
    q.pop_ready = pr;
  endtask
  task automatic wait_ready(input string n, input int exp);
    int k = 0;
    while (q.busy && k < 200) begin
      step();
      k++;
    end
    chk(n, k, exp);
  endtask
  task automatic do_clear();
    q.clear = 1'b1;
    step();
    q.clear = 1'b0;
    wait_ready("clear_latency", H);
    for (int i = 0; i < W; i++) for (int j = 0; j < H; j++) vis[i][j] = 1'b0;
    mq.delete();
  endtask
  function automatic vec_t mk(string n, bit pv, int x, int y, bit pr, int cnt, bit dup, bit oob, bit pvl, int px, int py);
    vec_t v;
    v.n = n; v.pv = pv; v.x = x; v.y = y; v.pr = pr; v.cnt = cnt;
    v.dup = dup; v.oob = oob; v.pvl = pvl; v.px = px; v.py = py;
    return v;
  endfunction
  initial begin
    q.clear = 0;
    drv(0, 0, 0, 0);
    s.clear = 0; s.push_valid = 0; s.push_x = 0; s.push_y = 0; s.pop_ready = 0;
    tv.push_back(mk("push_34", 1, 3, 4, 0, 1, 0, 0, 1, 3, 4));
    tv.push_back(mk("push_35", 1, 3, 5, 0, 2, 0, 0, 1, 3, 4));
    tv.push_back(mk("push_44", 1, 4, 4, 0, 3, 0, 0, 1, 3, 4));
    tv.push_back(mk("pop_1", 0, 0, 0, 1, 2, 0, 0, 1, 3, 5));
    tv.push_back(mk("pop_2", 0, 0, 0, 1, 1, 0, 0, 1, 4, 4));
    tv.push_back(mk("pop_3", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk("push_77", 1, 7, 7, 0, 1, 0, 0, 1, 7, 7));
    tv.push_back(mk("dup_77", 1, 7, 7, 0, 1, 1, 0, 1, 7, 7));
    tv.push_back(mk("dup_end", 0, 0, 0, 0, 1, 0, 0, 1, 7, 7));
    tv.push_back(mk("oob_xneg", 1, 63, 0, 0, 1, 0, 1, 1, 7, 7));
    tv.push_back(mk("oob_x32", 1, 32, 0, 0, 1, 0, 1, 1, 7, 7));
    tv.push_back(mk("oob_end", 0, 0, 0, 0, 1, 0, 0, 1, 7, 7));
    tv.push_back(mk("oob_y40", 1, 0, 40, 0, 1, 0, 1, 1, 7, 7));
    tv.push_back(mk("push_pop", 1, 9, 9, 1, 1, 0, 0, 1, 9, 9));
    tv.push_back(mk("pop_99", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk("dup_34", 1, 3, 4, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk("push_max", 1, 31, 31, 0, 1, 0, 0, 1, 31, 31));
    tv.push_back(mk("push_empty_pop", 1, 1, 1, 1, 1, 0, 0, 1, 1, 1));
    tv.push_back(mk("pop_both", 1, 2, 2, 1, 1, 0, 0, 1, 2, 2));
    tv.push_back(mk("pop_last", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    #12;
    chk("rst_busy", q.busy, 1);
    chk("rst_push_ready", q.push_ready, 0);
    chk("rst_pop_valid", q.pop_valid, 0);
    chk("rst_count", q.count, 0);
    chk("rst_drops", {q.dup_drop, q.oob_drop}, 0);
    chk("rst_pop_xy", {q.pop_x, q.pop_y}, 0);
    Reset_n = 1'b1;
    wait_ready("rst_latency", H);
    chk("rdy_push_ready", q.push_ready, 1);
    chk("rdy_count", q.count, 0);
    chk("rdy_pop_valid", q.pop_valid, 0);
    foreach (tv[i]) begin
      drv(tv[i].pv, tv[i].x, tv[i].y, tv[i].pr);
      step();
      chk({tv[i].n, "_count"}, q.count, tv[i].cnt);
      chk({tv[i].n, "_dup"}, q.dup_drop, tv[i].dup);
      chk({tv[i].n, "_oob"}, q.oob_drop, tv[i].oob);
      chk({tv[i].n, "_pvalid"}, q.pop_valid, tv[i].pvl);
      chk({tv[i].n, "_head"}, {q.pop_x, q.pop_y}, {tv[i].px[4:0], tv[i].py[4:0]});
    end
    for (int i = 0; i < 5; i++) begin
      drv(1, 10, i, 0);
      step();
    end
    chk("five_count", q.count, 5);
    drv(1, 10, 0, 1);
    q.clear = 1'b1;
    step();
    q.clear = 1'b0;
    drv(0, 0, 0, 0);
    chk("clr_count", q.count, 0);
    chk("clr_busy", q.busy, 1);
    chk("clr_drops", {q.dup_drop, q.oob_drop}, 0);
    wait_ready("clr_latency", H);
    drv(1, 10, 0, 0);
    step();
    drv(0, 0, 0, 0);
    chk("reuse_count", q.count, 1);
    chk("reuse_dup", q.dup_drop, 0);
    chk("reuse_head", {q.pop_x, q.pop_y}, {5'd10, 5'd0});
    do_clear();
    for (int c = 0; c < 600; c++) begin
      bit pv, pr, o, d, pf;
      int x, y;
      pv = ($urandom % 4) != 0;
      pr = ($urandom % 2) != 0;
      x = ($urandom % 8 != 0) ? $urandom_range(0, 7) : $urandom_range(0, 63);
      y = ($urandom % 8 != 0) ? $urandom_range(0, 7) : $urandom_range(0, 63);
      o = pv && (x >= W || y >= H);
      d = pv && !o && vis[x][y];
      pf = pr && mq.size() > 0;
      drv(pv, x, y, pr);
      step();
      if (pf) void'(mq.pop_front());
      if (pv && !o && !d) begin
        mq.push_back(x * 32 + y);
        vis[x][y] = 1'b1;
      end
      chk("rnd_count", q.count, mq.size());
      chk("rnd_dup", q.dup_drop, d);
      chk("rnd_oob", q.oob_drop, o);
      chk("rnd_pvalid", q.pop_valid, mq.size() > 0);
      if (mq.size() > 0) chk("rnd_head", 32'(q.pop_x) * 32 + 32'(q.pop_y), mq[0]);
    end
    drv(0, 0, 0, 0);
    do_clear();
    for (int c = 0; c < D; c++) begin
      drv(1, c % W, c / W, 0);
      step();
    end
    chk("full_count", q.count, D);
    chk("full_push_ready", q.push_ready, 0);
    chk("full_head", {q.pop_x, q.pop_y}, 0);
    drv(1, 5, 5, 0);
    step();
    chk("full_hold_count", q.count, D);
    chk("full_hold_dup", q.dup_drop, 0);
    drv(0, 0, 0, 1);
    step();
    chk("full_pop1", q.count, D - 1);
    drv(1, 5, 5, 0);
    step();
    chk("full_dup", q.dup_drop, 1);
    chk("full_dup_count", q.count, D - 1);
    drv(0, 0, 0, 1);
    for (int c = 1; c < D; c++) begin
      chk("drain_head", 32'(q.pop_x) * 32 + 32'(q.pop_y), (c % W) * 32 + c / W);
      step();
    end
    drv(0, 0, 0, 0);
    chk("drain_count", q.count, 0);
    for (int i = 0; i < 8; i++) begin
      s.push_valid = 1; s.push_x = 6'(i); s.push_y = 6'd1;
      step();
    end
    s.push_valid = 0;
    chk("sm_full_count", s.count, 8);
    chk("sm_full_ready", s.push_ready, 0);
    s.pop_ready = 1;
    step();
    s.pop_ready = 0;
    chk("sm_pop_count", s.count, 7);
    s.push_valid = 1; s.push_x = 6'd20; s.push_y = 6'd20;
    step();
    s.push_valid = 0;
    chk("sm_wrap_count", s.count, 8);
    s.pop_ready = 1;
    for (int i = 1; i < 9; i++) begin
      chk("sm_wrap_head", {s.pop_x, s.pop_y}, i < 8 ? {5'(i), 5'd1} : {5'd20, 5'd20});
      step();
    end
    s.pop_ready = 0;
    chk("sm_empty", s.pop_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
